// File: rtl/seg_pkg.sv
// Shared encodings for the multiplexed 7-segment scan controller.
package seg_pkg;
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;
endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module seg_scan_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          tc
);
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (count_q != '0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign tc = (count_q == '0);
endmodule

// File: rtl/seg_scan_controller.sv
// Scans NUM_DIGITS nibbles onto a shared segment decoder with a blank gap before
// each digit; new frames are double-buffered and only land on frame boundaries.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        scan_en,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [NIB_W*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]       load_blank,
    output logic [NIB_W-1:0]            nibble_out,
    output logic [NUM_DIGITS-1:0]       digit_en,
    output logic                        frame_done
);
    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int DW   = NIB_W * NUM_DIGITS;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  loaded_q, loaded_d;
    logic                  load_ready_q, load_ready_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic [NIB_W-1:0]      nibble_q, nibble_d;
    logic                  frame_done_q, frame_done_d;

    logic          tmr_load, tmr_tc, promote, accept;
    logic [CW-1:0] tmr_val;

    seg_scan_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    assign accept = load_valid & load_ready_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        act_data_d   = act_data_q;
        act_blank_d  = act_blank_q;
        pend_data_d  = pend_data_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        loaded_d     = loaded_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        promote      = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (scan_en && (pend_valid_q || loaded_q)) begin
                    promote  = pend_valid_q;
                    state_d  = ST_BLANK;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(BLANK_CYCLES - 1);
                end
            end
            ST_BLANK: begin
                if (!scan_en) begin
                    state_d  = ST_IDLE;
                    tmr_load = 1'b1;
                end else if (tmr_tc) begin
                    state_d  = ST_DRIVE;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(DWELL_CYCLES - 1);
                end
            end
            ST_DRIVE: begin
                if (!scan_en) begin
                    state_d  = ST_IDLE;
                    tmr_load = 1'b1;
                end else if (tmr_tc) begin
                    state_d  = ST_BLANK;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(BLANK_CYCLES - 1);
                    if (idx_q == IW'(NUM_DIGITS - 1)) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                        promote      = pend_valid_q;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Promotion needs pend_valid_q=1, which holds load_ready low, so it never
        // coincides with an accept.
        if (promote) begin
            act_data_d   = pend_data_q;
            act_blank_d  = pend_blank_q;
            pend_valid_d = 1'b0;
            loaded_d     = 1'b1;
        end
        if (accept) begin
            pend_data_d  = load_data;
            pend_blank_d = load_blank;
            pend_valid_d = 1'b1;
        end
        load_ready_d = !pend_valid_d;

        // Outputs are registered from the next-state view so they line up with state_q.
        digit_en_d = '0;
        if (state_d == ST_DRIVE && !act_blank_d[idx_d])
            digit_en_d[idx_d] = 1'b1;
        nibble_d = (state_d == ST_IDLE) ? '0 : act_data_d[idx_d*NIB_W +: NIB_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            act_data_q   <= '0;
            act_blank_q  <= '0;
            pend_data_q  <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            loaded_q     <= 1'b0;
            load_ready_q <= 1'b1;
            digit_en_q   <= '0;
            nibble_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            act_data_q   <= act_data_d;
            act_blank_q  <= act_blank_d;
            pend_data_q  <= pend_data_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            loaded_q     <= loaded_d;
            load_ready_q <= load_ready_d;
            digit_en_q   <= digit_en_d;
            nibble_q     <= nibble_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign digit_en   = digit_en_q;
    assign nibble_out = nibble_q;
    assign frame_done = frame_done_q;
endmodule
